// File: rtl/bram_fifo_if.sv
// bram_fifo_if: push/pop stream and block-RAM port bundle for the FIFO controller
interface bram_fifo_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W+1:0] count;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dia;
  logic              ram_ena;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addrb;
  logic              ram_enb;
  logic              ram_ssrb;
  logic [DATA_W-1:0] ram_dob;
  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_dob,
    output wr_ready, rd_valid, rd_data, count,
           ram_addra, ram_dia, ram_ena, ram_wea, ram_addrb, ram_enb, ram_ssrb
  );
  modport master (
    output wr_valid, wr_data, rd_ready, ram_dob,
    input  wr_ready, rd_valid, rd_data, count,
           ram_addra, ram_dia, ram_ena, ram_wea, ram_addrb, ram_enb, ram_ssrb
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: block-RAM FIFO controller with a 2-entry first-word-fall-through output buffer
module bram_fifo_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
) (
  input logic       clk,
  input logic       rst,
  bram_fifo_if.slave bus
);
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   ram_cnt;
  logic [ADDR_W+1:0] cnt;
  logic [1:0]        ob_cnt;
  logic              inflight;
  logic [DATA_W-1:0] ob0, ob1;
  logic              wr_ready, push, pop, issue;
  // ram_cnt tops out at DEPTH, so its MSB alone marks the RAM as full
  assign wr_ready = !rst && !ram_cnt[ADDR_W];
  assign push     = bus.wr_valid && wr_ready;
  assign pop      = bus.rd_ready && (ob_cnt != 2'd0);
  // issue only when the word is guaranteed a buffer slot on arrival
  assign issue    = !rst && (ram_cnt != '0) &&
                    (({1'b0, ob_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = ob_cnt != 2'd0;
  assign bus.rd_data   = ob0;
  assign bus.count     = cnt;
  assign bus.ram_addra = wptr;
  assign bus.ram_dia   = bus.wr_data;
  assign bus.ram_ena   = push;
  assign bus.ram_wea   = push;
  assign bus.ram_addrb = rptr;
  assign bus.ram_enb   = issue;
  assign bus.ram_ssrb  = 1'b0;
  // pointers, occupancy and output buffer; ob0 is always the head word
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      cnt      <= '0;
      ob_cnt   <= '0;
      inflight <= 1'b0;
      ob0      <= '0;
      ob1      <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      ram_cnt  <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
      cnt      <= cnt + (ADDR_W+2)'(push) - (ADDR_W+2)'(pop);
      inflight <= issue;
      ob_cnt   <= ob_cnt + 2'(inflight) - 2'(pop);
      if (inflight) ob1 <= bus.ram_dob;
      ob0 <= pop ? (ob_cnt == 2'd2 ? ob1 : bus.ram_dob)
                 : (ob_cnt == 2'd0 ? bus.ram_dob : ob0);
    end
  end
endmodule
